mlp_stream_sequencer: RTL and testbench

- Autonomous host-side controller that drives the Top accelerator's `ready`/`i_en`/`data_in` load interface and collects its `valid`/`ofmap` results.
- Runs a two-pass MLP layer:
  - per pass, stream 16 ifmap words, then 1024 weight words, then 64 bias words from a word-addressed input memory;
  - then capture 64 result words.
- Replaces hand-sequenced bench stimulus; used in system integration and as the bench driver.
- Mode 1 chains layers: pass-0 results are written back as the pass-1 bias region.

---
 rtl/mlp_stream_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_mlp_stream_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_stream_sequencer.sv
// mlp_stream_sequencer
//   Host-side controller for the MLP accelerator load interface. Runs two
//   passes. Each pass streams ifmap, weight and bias words from a
//   word-addressed input memory into the accelerator, then captures the
//   result words. In chained mode (mode=1) the pass-0 results are written
//   back into the input memory as the pass-1 bias region.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, mode       launch pulse (honoured in IDLE), chaining select
//   busy, done        run in progress, one-cycle completion pulse
//   mem_*             input memory: read strobe/address, 1-cycle read data,
//                     write strobe/data for chained write-back
//   acc_mode          latched mode, to the accelerator
//   acc_ready/i_en/data_in   accelerator load interface
//   acc_valid/ofmap   accelerator result interface
//   res_we/addr/wdata result memory write port
//
// States
//   IDLE      | waiting for start
//   WAIT_IDLE | waiting for the accelerator to stop presenting results
//   KICK      | one-cycle acc_ready pulse, first read issued
//   STREAM    | reading the rest of the pass, one word per cycle
//   COLLECT   | waiting for all result words of the pass
//   FINISH    | done pulse, back to IDLE

module mlp_stream_sequencer #(
  parameter int IFMAP_WORDS  = 16,
  parameter int WEIGHT_WORDS = 1024,
  parameter int BIAS_WORDS   = 64,
  parameter int OFMAP_WORDS  = 64,
  parameter int ADDR_W       = 12,
  parameter int RES_AW       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              acc_mode,
  output logic              acc_ready,
  output logic              acc_i_en,
  output logic [31:0]       acc_data_in,
  input  logic              acc_valid,
  input  logic [31:0]       acc_ofmap,
  output logic              res_we,
  output logic [RES_AW-1:0] res_addr,
  output logic [31:0]       res_wdata
);

  localparam int PASS_LEN = IFMAP_WORDS + WEIGHT_WORDS + BIAS_WORDS;
  localparam int CNT_W    = $clog2(PASS_LEN + 1);
  localparam int K_W      = $clog2(OFMAP_WORDS + 1);

  localparam logic [ADDR_W-1:0] PASS1_BASE = ADDR_W'(PASS_LEN);
  // pass-1 bias region, target of chained write-back
  localparam logic [ADDR_W-1:0] WB_BASE    = ADDR_W'(PASS_LEN + IFMAP_WORDS + WEIGHT_WORDS);
  localparam logic [K_W-1:0]    K_LAST     = K_W'(OFMAP_WORDS);
  localparam logic [CNT_W-1:0]  RD_LOAD    = CNT_W'(PASS_LEN - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_IDLE = 3'd1;
  localparam logic [2:0] S_KICK      = 3'd2;
  localparam logic [2:0] S_STREAM    = 3'd3;
  localparam logic [2:0] S_COLLECT   = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  logic [2:0]        state;
  logic              pass;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_left;
  logic [K_W-1:0]    k;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_data;

  logic [ADDR_W-1:0] base;
  logic              issue;
  logic              capture;

  assign base = pass ? PASS1_BASE : '0;

  // A pending write-back owns the memory port; the stream read waits a cycle.
  assign issue   = (state == S_STREAM) && !wb_valid;
  assign capture = acc_valid && ((state == S_STREAM) || (state == S_COLLECT)) && (k < K_LAST);

  assign acc_ready   = (state == S_KICK);
  assign mem_rd      = acc_ready || issue;
  assign mem_we      = wb_valid;
  assign mem_wdata   = wb_valid ? wb_data : '0;
  assign acc_data_in = acc_i_en ? mem_rdata : '0;
  assign busy        = (state != S_IDLE) && (state != S_FINISH);
  assign done        = (state == S_FINISH);

  always_comb begin
    mem_addr = '0;
    if (wb_valid)
      mem_addr = wb_addr;
    else if (state == S_KICK)
      mem_addr = base;
    else if (issue)
      mem_addr = rd_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pass      <= 1'b0;
      acc_mode  <= 1'b0;
      rd_addr   <= '0;
      rd_left   <= '0;
      k         <= '0;
      acc_i_en  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      res_we    <= 1'b0;
      res_addr  <= '0;
      res_wdata <= '0;
    end else begin
      acc_i_en <= mem_rd;
      wb_valid <= 1'b0;
      res_we   <= 1'b0;

      if (capture) begin
        k <= k + 1'b1;
        if (acc_mode && !pass) begin
          wb_valid <= 1'b1;
          wb_addr  <= WB_BASE + ADDR_W'(k);
          wb_data  <= acc_ofmap;
        end else begin
          // independent mode keeps both passes; chained mode only the last
          res_we    <= 1'b1;
          res_addr  <= ((pass && !acc_mode) ? RES_AW'(OFMAP_WORDS) : '0) + RES_AW'(k);
          res_wdata <= acc_ofmap;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_WAIT_IDLE;
            acc_mode <= mode;
            pass     <= 1'b0;
          end
        end
        S_WAIT_IDLE: begin
          if (!acc_valid)
            state <= S_KICK;
        end
        S_KICK: begin
          state   <= S_STREAM;
          rd_addr <= base + 1'b1;
          rd_left <= RD_LOAD;
          k       <= '0;
        end
        S_STREAM: begin
          if (issue) begin
            rd_addr <= rd_addr + 1'b1;
            rd_left <= rd_left - 1'b1;
            if (rd_left == CNT_W'(1))
              state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (k == K_LAST) begin
            if (!pass) begin
              pass  <= 1'b1;
              state <= S_WAIT_IDLE;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_stream_sequencer.sv
`timescale 1ns/1ps
module tb_mlp_stream_sequencer;

  localparam int PASS_LEN = 1104;
  localparam int WB_BASE  = 2144;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        busy, done;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        acc_mode, acc_ready, acc_i_en;
  logic [31:0] acc_data_in;
  logic        acc_valid = 1'b0;
  logic [31:0] acc_ofmap = '0;
  logic        res_we;
  logic [6:0]  res_addr;
  logic [31:0] res_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mlp_stream_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .acc_mode(acc_mode), .acc_ready(acc_ready), .acc_i_en(acc_i_en),
    .acc_data_in(acc_data_in), .acc_valid(acc_valid), .acc_ofmap(acc_ofmap),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  // input memory: 1-cycle read latency, garbage when not reading
  logic [31:0] mem [0:4095];
  logic        mem_init_req = 1'b0;
  always @(posedge clk) begin
    if (mem_init_req) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 32'(a);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 32'hDEAD_BEEF;
  end

  // accelerator result model
  int  gen_style = 0;
  int  emit_n = 64;
  bit  hold_valid = 1'b0;
  bit  tb_mode1 = 1'b0;
  int  mp = -1, beats = 0, emitted = 0;
  bit  tog = 1'b0, m_busy_prev = 1'b0, m_fire = 1'b0;

  always @(posedge clk) begin
    #2;
    if (busy && !m_busy_prev) mp = -1;
    m_busy_prev = busy;
    if (acc_ready) begin mp++; beats = 0; emitted = 0; tog = 1'b0; end
    if (acc_i_en) beats++;
    acc_valid = 1'b0;
    acc_ofmap = '0;
    if (hold_valid) begin
      acc_valid = 1'b1;
      acc_ofmap = 32'hFFFF_FFFF;
    end else if (mp >= 0 && emitted < emit_n) begin
      m_fire = 1'b0;
      if (gen_style == 1) m_fire = (beats >= PASS_LEN);
      else if (gen_style == 2 && beats >= 4) begin m_fire = tog; tog = !tog; end
      if (m_fire) begin
        acc_valid = 1'b1;
        if (tb_mode1) acc_ofmap = (mp == 0 ? 32'h0000_A000 : 32'h0000_C000) + 32'(emitted);
        else          acc_ofmap = 32'h5000_0000 + 32'(mp * 64 + emitted);
        emitted++;
      end
    end
  end

  // protocol monitor
  int ready_cnt = 0, ien_cnt = 0, res_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int data_err = 0, res_err = 0, wr_err = 0, prot_err = 0;
  int run_ien = 0, run_res = 0, run_wr = 0, run_ready = 0;
  bit prev_ready = 1'b0, mon_busy_prev = 1'b0;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    if (busy && !mon_busy_prev) begin run_ien = 0; run_res = 0; run_wr = 0; run_ready = 0; end
    mon_busy_prev = busy;
    if (prev_ready && !acc_i_en) prot_err++;
    prev_ready = acc_ready;
    if (acc_ready) begin
      ready_cnt++; run_ready++;
      if (acc_i_en) prot_err++;
    end
    if (acc_i_en) begin
      if (tb_mode1 && run_ien >= WB_BASE) mon_exp = 32'h0000_A000 + 32'(run_ien - WB_BASE);
      else                                mon_exp = 32'(run_ien);
      if (acc_data_in !== mon_exp) data_err++;
      ien_cnt++; run_ien++;
    end else if (acc_data_in !== 32'h0) begin
      data_err++;
    end
    if (res_we) begin
      mon_exp = tb_mode1 ? 32'h0000_C000 + 32'(run_res) : 32'h5000_0000 + 32'(run_res);
      if (res_addr !== 7'(run_res) || res_wdata !== mon_exp || (tb_mode1 && run_ready < 2)) res_err++;
      res_cnt++; run_res++;
    end
    if (mem_we) begin
      if (mem_rd || !tb_mode1 || mem_addr !== 12'(WB_BASE + run_wr) ||
          mem_wdata !== 32'h0000_A000 + 32'(run_wr)) wr_err++;
      wr_cnt++; run_wr++;
    end
    if (done) begin
      done_cnt++;
      if (busy) prot_err++;
    end
  end

  task automatic init_mem;
    @(posedge clk); #1; mem_init_req = 1'b1;
    @(posedge clk); #1; mem_init_req = 1'b0;
  endtask

  task automatic launch(input bit m, input int style, input int n);
    @(posedge clk); #1;
    tb_mode1 = m; gen_style = style; emit_n = n; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    tests++;
    if ({busy, done, acc_ready, acc_i_en, mem_rd, mem_we, res_we, acc_mode} !== 8'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {busy, done, acc_ready, acc_i_en, mem_rd, mem_we, res_we, acc_mode});
    end
    tests++;
    if (mem_addr !== 12'h0 || acc_data_in !== 32'h0 || res_addr !== 7'h0 ||
        res_wdata !== 32'h0 || mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: mem_addr=%h data_in=%h res_addr=%h res_wdata=%h mem_wdata=%h, all expected 0",
               mem_addr, acc_data_in, res_addr, res_wdata, mem_wdata);
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_mode0;
    int r0, i0, s0, w0, d0, de0, re0, pe0;
    bit ok;
    init_mem;
    r0 = ready_cnt; i0 = ien_cnt; s0 = res_cnt; w0 = wr_cnt; d0 = done_cnt;
    de0 = data_err; re0 = res_err; pe0 = prot_err + wr_err;
    launch(1'b0, 1, 64);
    wait_done(6000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL m0_done_timeout: done not seen, expected within 6000 cycles"); end
    tests++; if (ready_cnt - r0 != 2) begin fails++; $display("FAIL m0_ready_pulses: got %0d expected 2", ready_cnt - r0); end
    tests++; if (ien_cnt - i0 != 2208) begin fails++; $display("FAIL m0_ien_beats: got %0d expected 2208", ien_cnt - i0); end
    tests++; if (data_err != de0) begin fails++; $display("FAIL m0_stream_data: %0d bad beats, expected 0", data_err - de0); end
    tests++; if (res_cnt - s0 != 128) begin fails++; $display("FAIL m0_res_writes: got %0d expected 128", res_cnt - s0); end
    tests++; if (res_err != re0) begin fails++; $display("FAIL m0_res_order: %0d bad writes, expected 0", res_err - re0); end
    tests++; if (wr_cnt != w0) begin fails++; $display("FAIL m0_no_writeback: got %0d mem writes expected 0", wr_cnt - w0); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL m0_done_pulses: got %0d expected 1", done_cnt - d0); end
    tests++; if (prot_err + wr_err != pe0) begin fails++; $display("FAIL m0_protocol: %0d violations, expected 0", prot_err + wr_err - pe0); end
    tests++; if (acc_mode !== 1'b0) begin fails++; $display("FAIL m0_acc_mode: got %b expected 0", acc_mode); end
  endtask

  task automatic test_mode1;
    int r0, i0, s0, w0, d0, de0, re0, we0, pe0;
    bit ok;
    init_mem;
    r0 = ready_cnt; i0 = ien_cnt; s0 = res_cnt; w0 = wr_cnt; d0 = done_cnt;
    de0 = data_err; re0 = res_err; we0 = wr_err; pe0 = prot_err;
    launch(1'b1, 1, 64);
    wait_done(6000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL m1_done_timeout: done not seen, expected within 6000 cycles"); end
    tests++; if (acc_mode !== 1'b1) begin fails++; $display("FAIL m1_acc_mode: got %b expected 1", acc_mode); end
    tests++; if (wr_cnt - w0 != 64) begin fails++; $display("FAIL m1_writebacks: got %0d expected 64", wr_cnt - w0); end
    tests++; if (wr_err != we0) begin fails++; $display("FAIL m1_writeback_addr_data: %0d bad writes, expected 0", wr_err - we0); end
    tests++; if (mem[WB_BASE] !== 32'h0000_A000 || mem[WB_BASE + 63] !== 32'h0000_A03F) begin
      fails++; $display("FAIL m1_mem_contents: mem[2144]=%h mem[2207]=%h expected 0000a000 0000a03f", mem[WB_BASE], mem[WB_BASE + 63]);
    end
    tests++; if (ien_cnt - i0 != 2208) begin fails++; $display("FAIL m1_ien_beats: got %0d expected 2208", ien_cnt - i0); end
    tests++; if (data_err != de0) begin fails++; $display("FAIL m1_stream_bias_readback: %0d bad beats, expected 0", data_err - de0); end
    tests++; if (res_cnt - s0 != 64) begin fails++; $display("FAIL m1_res_writes: got %0d expected 64", res_cnt - s0); end
    tests++; if (res_err != re0) begin fails++; $display("FAIL m1_res_order: %0d bad writes, expected 0", res_err - re0); end
    tests++; if (ready_cnt - r0 != 2 || done_cnt - d0 != 1 || prot_err != pe0) begin
      fails++; $display("FAIL m1_framing: ready=%0d done=%0d prot=%0d expected 2 1 0", ready_cnt - r0, done_cnt - d0, prot_err - pe0);
    end
  endtask

  task automatic test_handshake;
    int r0, pe0;
    bit ok;
    init_mem;
    r0 = ready_cnt; pe0 = prot_err;
    @(posedge clk); #1;
    tb_mode1 = 1'b0; gen_style = 1; emit_n = 64; hold_valid = 1'b1; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #1; hold_valid = 1'b0;
    tests++; if (ready_cnt != r0) begin fails++; $display("FAIL hs_ready_during_hold: got %0d pulses expected 0", ready_cnt - r0); end
    @(negedge clk);
    tests++; if (acc_ready !== 1'b0) begin fails++; $display("FAIL hs_ready_on_fall: got %b expected 0", acc_ready); end
    @(negedge clk);
    tests++; if (acc_ready !== 1'b1 || acc_i_en !== 1'b0) begin
      fails++; $display("FAIL hs_ready_after_fall: ready=%b i_en=%b expected 1 0", acc_ready, acc_i_en);
    end
    @(negedge clk);
    tests++; if (acc_i_en !== 1'b1 || acc_ready !== 1'b0) begin
      fails++; $display("FAIL hs_first_ien: i_en=%b ready=%b expected 1 0", acc_i_en, acc_ready);
    end
    wait_done(6000, ok);
    tests++; if (!ok || prot_err != pe0) begin
      fails++; $display("FAIL hs_completion: done=%b prot=%0d expected 1 0", ok, prot_err - pe0);
    end
  endtask

  task automatic test_start_busy;
    int r0, i0, s0, d0, re0;
    bit ok, reached;
    init_mem;
    r0 = ready_cnt; i0 = ien_cnt; s0 = res_cnt; d0 = done_cnt; re0 = res_err;
    launch(1'b0, 1, 68);
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ien_cnt - i0 >= 100) begin reached = 1'b1; break; end
    end
    tests++; if (!reached) begin fails++; $display("FAIL sb_reach_stream: got %0d beats expected 100", ien_cnt - i0); end
    @(posedge clk); #1; start = 1'b1; mode = 1'b1;
    @(posedge clk); #1; start = 1'b0; mode = 1'b0;
    wait_done(6000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL sb_done_timeout: done not seen, expected within 6000 cycles"); end
    tests++; if (acc_mode !== 1'b0) begin fails++; $display("FAIL sb_mode_kept: got %b expected 0", acc_mode); end
    tests++; if (ien_cnt - i0 != 2208) begin fails++; $display("FAIL sb_ien_beats: got %0d expected 2208", ien_cnt - i0); end
    tests++; if (ready_cnt - r0 != 2 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL sb_no_restart: ready=%0d done=%0d expected 2 1", ready_cnt - r0, done_cnt - d0);
    end
    tests++; if (res_cnt - s0 != 128 || res_err != re0) begin
      fails++; $display("FAIL sb_excess_dropped: res=%0d bad=%0d expected 128 0", res_cnt - s0, res_err - re0);
    end
  endtask

  task automatic test_reset_mid;
    int i0, s0, d0, de0, re0;
    bit ok, reached;
    init_mem;
    i0 = ien_cnt; d0 = done_cnt;
    launch(1'b0, 1, 64);
    reached = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (ien_cnt - i0 >= PASS_LEN + 500) begin reached = 1'b1; break; end
    end
    tests++; if (!reached) begin fails++; $display("FAIL rm_reach_beat: got %0d beats expected 1604", ien_cnt - i0); end
    #2; rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, acc_ready, acc_i_en, mem_rd, mem_we, res_we} !== 7'b0 ||
        mem_addr !== 12'h0 || acc_data_in !== 32'h0 || acc_mode !== 1'b0) begin
      fails++;
      $display("FAIL rm_async_clear: ctrl=%b mem_addr=%h data_in=%h acc_mode=%b expected all 0",
               {busy, done, acc_ready, acc_i_en, mem_rd, mem_we, res_we}, mem_addr, acc_data_in, acc_mode);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (done_cnt != d0 || busy !== 1'b0) begin
      fails++; $display("FAIL rm_no_done: done pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
    end
    i0 = ien_cnt; s0 = res_cnt; d0 = done_cnt; de0 = data_err; re0 = res_err;
    launch(1'b0, 1, 64);
    wait_done(6000, ok);
    tests++; if (!ok || done_cnt - d0 != 1) begin
      fails++; $display("FAIL rm_rerun_done: seen=%b pulses=%0d expected 1 1", ok, done_cnt - d0);
    end
    tests++; if (ien_cnt - i0 != 2208 || data_err != de0) begin
      fails++; $display("FAIL rm_rerun_stream: beats=%0d bad=%0d expected 2208 0", ien_cnt - i0, data_err - de0);
    end
    tests++; if (res_cnt - s0 != 128 || res_err != re0) begin
      fails++; $display("FAIL rm_rerun_results: res=%0d bad=%0d expected 128 0", res_cnt - s0, res_err - re0);
    end
  endtask

  task automatic test_gapped;
    int i0, s0, w0, d0, de0, re0, we0;
    bit ok;
    init_mem;
    i0 = ien_cnt; s0 = res_cnt; w0 = wr_cnt; d0 = done_cnt;
    de0 = data_err; re0 = res_err; we0 = wr_err;
    launch(1'b1, 2, 64);
    wait_done(6000, ok);
    tests++; if (!ok || done_cnt - d0 != 1) begin
      fails++; $display("FAIL gap_done: seen=%b pulses=%0d expected 1 1", ok, done_cnt - d0);
    end
    tests++; if (wr_cnt - w0 != 64) begin fails++; $display("FAIL gap_writebacks: got %0d expected 64", wr_cnt - w0); end
    tests++; if (wr_err != we0) begin fails++; $display("FAIL gap_port_conflict: %0d bad writes, expected 0", wr_err - we0); end
    tests++; if (ien_cnt - i0 != 2208) begin fails++; $display("FAIL gap_ien_beats: got %0d expected 2208", ien_cnt - i0); end
    tests++; if (data_err != de0) begin fails++; $display("FAIL gap_stream_order: %0d bad beats, expected 0", data_err - de0); end
    tests++; if (res_cnt - s0 != 64 || res_err != re0) begin
      fails++; $display("FAIL gap_results: res=%0d bad=%0d expected 64 0", res_cnt - s0, res_err - re0);
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode1;
    test_handshake;
    test_start_busy;
    test_reset_mid;
    test_gapped;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation exceeded 2 ms");
    $fatal(1, "timeout");
  end

endmodule
